regfile_param: RTL and testbench

//  Parametrised 2-read/1-write register file for the CPU decode/writeback stages.

---
 rtl/regfile_param.sv | 128 ++++++++++++
 tb/tb_regfile_param.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_param
//  Description : Parametrised 2-read/1-write register file with optional
//                hardwired-zero register 0, a sequential clear engine
//                (one register per cycle) and a debug tap of one register.
//                Optional write-first forwarding when REGFILE_BYPASS_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int TAP_REG  = 14
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              ctrl_clear,
  output logic              clear_busy,
  output logic              write_dropped,
  output logic [DATA_W-1:0] reg_tap
);

  localparam int                c_NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(c_NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_TAP_IDX  = ADDR_W'(TAP_REG);
  localparam logic              c_ZERO_EN  = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_countNext;
  logic              w_clearStep;
  logic              w_writeAccept;
  logic [DATA_W-1:0] r_regs [c_NUM_REGS];
  logic [DATA_W-1:0] w_arrA;
  logic [DATA_W-1:0] w_arrB;
  logic [DATA_W-1:0] w_arrTap;

  // Clear FSM state and sweep counter registers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Next-state logic: a clear sweeps every index once, then returns to IDLE
  // with the counter wrapped back to zero.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_clearStep = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctrl_clear) begin
          w_stateNext = CLEAR;
          w_countNext = '0;
        end
      end
      CLEAR: begin
        w_clearStep = 1'b1;
        w_countNext = r_count + ADDR_W'(1);
        if (r_count == c_LAST_IDX) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_countNext = '0;
      end
    endcase
  end

  assign clear_busy    = (r_state == CLEAR);
  assign write_dropped = ctrl_writeEnable & clear_busy;

  // Writes to the hardwired-zero register are discarded here so they never
  // reach the array nor the forwarding path.
  assign w_writeAccept = ctrl_writeEnable & ~clear_busy &
                         (~c_ZERO_EN | (ctrl_writeReg != '0));

  // Register array: reset, clear sweep, or an accepted write.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clearStep) begin
      r_regs[r_count] <= '0;
    end else if (w_writeAccept) begin
      r_regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  assign w_arrA   = (c_ZERO_EN && ctrl_readRegA == '0) ? '0 : r_regs[ctrl_readRegA];
  assign w_arrB   = (c_ZERO_EN && ctrl_readRegB == '0) ? '0 : r_regs[ctrl_readRegB];
  assign w_arrTap = (c_ZERO_EN && c_TAP_IDX == '0)     ? '0 : r_regs[c_TAP_IDX];

`ifdef REGFILE_BYPASS_EN
  // Write-first forwarding; w_writeAccept already excludes register 0.
  assign data_readRegA = (w_writeAccept && ctrl_readRegA == ctrl_writeReg) ? data_writeReg : w_arrA;
  assign data_readRegB = (w_writeAccept && ctrl_readRegB == ctrl_writeReg) ? data_writeReg : w_arrB;
  assign reg_tap       = (w_writeAccept && c_TAP_IDX == ctrl_writeReg)     ? data_writeReg : w_arrTap;
`else
  assign data_readRegA = w_arrA;
  assign data_readRegB = w_arrB;
  assign reg_tap       = w_arrTap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_param
//  Description : Self-checking bench for regfile_param (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [4:0]  ctrl_readRegA = '0;
  logic [4:0]  ctrl_readRegB = '0;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        ctrl_clear = 1'b0;
  logic        clear_busy;
  logic        write_dropped;
  logic [31:0] reg_tap;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .TAP_REG(14)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .ctrl_clear       (ctrl_clear),
    .clear_busy       (clear_busy),
    .write_dropped    (write_dropped),
    .reg_tap          (reg_tap)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mRegs [32];
  int          mRemain = 0;   // clear cycles still to run
  int          mIdx = 0;      // next index the sweep zeroes

  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
      mRemain = 0;
      mIdx = 0;
    end else begin
      bit wasBusy;
      wasBusy = (mRemain > 0);
      if (wasBusy) begin
        mRegs[mIdx] = '0;
        mIdx = mIdx + 1;
        mRemain = mRemain - 1;
      end else if (ctrl_clear) begin
        mRemain = 32;
        mIdx = 0;
      end
      if (ctrl_writeEnable && !wasBusy && ctrl_writeReg != 0)
        mRegs[ctrl_writeReg] = data_writeReg;
    end
  end

  function automatic logic [31:0] modelRead(input int idx);
    logic accept;
    accept = ctrl_writeEnable && (mRemain == 0) && (ctrl_writeReg != 0);
`ifdef REGFILE_BYPASS_EN
    if (accept && idx == int'(ctrl_writeReg)) return data_writeReg;
`endif
    if (idx == 0) return '0;
    return mRegs[idx];
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clock) begin
    if (checkEn) begin
      chk("cmpReadA", data_readRegA, modelRead(int'(ctrl_readRegA)));
      chk("cmpReadB", data_readRegB, modelRead(int'(ctrl_readRegB)));
      chk("cmpTap", reg_tap, modelRead(14));
      chk("cmpBusy", {31'b0, clear_busy}, {31'b0, mRemain > 0});
      chk("cmpDropped", {31'b0, write_dropped}, {31'b0, ctrl_writeEnable && (mRemain > 0)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = idx;
    data_writeReg = val;
    cyc();
    ctrl_writeEnable = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset state
    #1;
    chk("rstReadA", data_readRegA, 32'h0);
    chk("rstTap", reg_tap, 32'h0);
    chk("rstBusy", {31'b0, clear_busy}, 32'h0);
    cyc();
    cyc();
    ctrl_reset = 1'b0;
    checkEn = 1'b1;

    // 1. basic write/read and hardwired zero
    wr(5'd5, 32'hDEADBEEF);
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    #1;
    chk("readA_r5", data_readRegA, 32'hDEADBEEF);
    chk("readB_r5", data_readRegB, 32'hDEADBEEF);
    wr(5'd0, 32'h1234);
    ctrl_readRegA = 5'd0;
    #1;
    chk("readZero", data_readRegA, 32'h0);
    chk("zeroNoDrop", {31'b0, write_dropped}, 32'h0);

    // 2. tap and async reset mid-cycle
    wr(5'd14, 32'hA5A5A5A5);
    #1;
    chk("tapValue", reg_tap, 32'hA5A5A5A5);
    ctrl_readRegA = 5'd14;
    ctrl_readRegB = 5'd5;
    #1;
    ctrl_reset = 1'b1;
    #1;
    chk("asyncTap", reg_tap, 32'h0);
    chk("asyncReadA", data_readRegA, 32'h0);
    chk("asyncReadB", data_readRegB, 32'h0);
    cyc();
    ctrl_reset = 1'b0;

    // 3. fill, then sweep-clear and track progress
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    ctrl_clear = 1'b1;
    cyc();
    ctrl_clear = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ctrl_readRegA = 5'(k);
      ctrl_readRegB = (k == 0) ? 5'd0 : 5'(k - 1);
      #1;
      chk("sweepBusy", {31'b0, clear_busy}, 32'h1);
      chk("sweepNotYet", data_readRegA, 32'(k));
      chk("sweepDone", data_readRegB, 32'h0);
      cyc();
    end
    chk("sweepEnd", {31'b0, clear_busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      #1;
      chk("allZero", data_readRegA, 32'h0);
    end

    // 4. write dropped during clear, re-trigger ignored
    wr(5'd31, 32'h99);
    ctrl_clear = 1'b1;
    cyc();
    ctrl_clear = 1'b0;
    n = 0;
    while (clear_busy === 1'b1 && n < 40) begin
      ctrl_writeEnable = (n == 5);
      ctrl_writeReg = 5'd31;
      data_writeReg = 32'h55;
      ctrl_clear = (n == 10);
      #1;
      if (n == 5) chk("dropFlag", {31'b0, write_dropped}, 32'h1);
      cyc();
      ctrl_writeEnable = 1'b0;
      ctrl_clear = 1'b0;
      n++;
    end
    chk("busyLen", 32'(n), 32'd32);
    ctrl_readRegA = 5'd31;
    #1;
    chk("r31Cleared", data_readRegA, 32'h0);

    // 5. reset during clear
    ctrl_clear = 1'b1;
    cyc();
    ctrl_clear = 1'b0;
    repeat (10) cyc();
    ctrl_reset = 1'b1;
    #1;
    chk("rstMidClear", {31'b0, clear_busy}, 32'h0);
    cyc();
    ctrl_reset = 1'b0;
    wr(5'd3, 32'd7);
    ctrl_readRegA = 5'd3;
    #1;
    chk("postRstWrite", data_readRegA, 32'd7);

    // 6. same-cycle write/read
    wr(5'd9, 32'h1111);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg = 5'd9;
    data_writeReg = 32'hCAFE;
    ctrl_readRegA = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("sameCycle", data_readRegA, 32'hCAFE);
`else
    chk("sameCycle", data_readRegA, 32'h1111);
`endif
    cyc();
    ctrl_writeEnable = 1'b0;
    #1;
    chk("nextCycle", data_readRegA, 32'hCAFE);

    cyc();
    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
